// File: rtl/event_unit_pkg.sv
// Shared definitions for the SoC event unit: default source count and the
// round-robin search helper used by the event FIFO arbiter.
package event_unit_pkg;

  localparam int SOC_EVT_NB_SRC_DEFAULT = 4;
  localparam int RR_MAX_SRC             = 32;

  // Returns the first set index at or after ptr, wrapping modulo n.
  // With no request set, ptr is returned; callers qualify it with |req.
  function automatic int unsigned rr_first(
    input logic [RR_MAX_SRC-1:0] req,
    input int unsigned           ptr,
    input int unsigned           n = SOC_EVT_NB_SRC_DEFAULT
  );
    int unsigned idx;
    rr_first = ptr;
    // Walk offsets from far to near so the nearest hit is the one that sticks.
    for (int k = RR_MAX_SRC - 1; k >= 0; k--) begin
      if (int'(n) > k) begin
        idx = ptr + int'(k);
        if (idx >= n) begin
          idx = idx - n;
        end
        if (req[idx]) begin
          rr_first = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/soc_evt_rr_arbiter.sv
// Combinational round-robin pick among pending event slots; the pointer
// register lives in the parent.
module soc_evt_rr_arbiter
  import event_unit_pkg::*;
#(
  parameter int NB_SRC = SOC_EVT_NB_SRC_DEFAULT,
  parameter int PTR_W  = $clog2(NB_SRC)
) (
  input  logic [NB_SRC-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              en,
  output logic [NB_SRC-1:0] gnt_onehot,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  logic [RR_MAX_SRC-1:0] req_ext;
  int unsigned           pick;

  assign req_ext   = RR_MAX_SRC'(req);
  assign gnt_valid = en & (|req);

  always_comb begin
    pick    = rr_first(req_ext, 32'(ptr), NB_SRC);
    gnt_idx = PTR_W'(pick);
  end

  for (genvar gi = 0; gi < NB_SRC; gi++) begin : g_onehot
    assign gnt_onehot[gi] = gnt_valid & (gnt_idx == PTR_W'(gi));
  end

endmodule

// File: rtl/soc_evt_fifo_arbiter.sv
// Merges per-source event pulses into the single event FIFO write port through
// one-entry pending slots, a round-robin grant and a registered output stage.
module soc_evt_fifo_arbiter
  import event_unit_pkg::*;
#(
  parameter int NB_SRC    = SOC_EVT_NB_SRC_DEFAULT,
  parameter int ID_WIDTH  = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_SRC-1:0]            src_evt_i,
  input  logic [NB_SRC*ID_WIDTH-1:0]   src_id_i,
  input  logic                         arb_en_i,
  output logic                         fifo_data_valid_o,
  output logic [ID_WIDTH-1:0]          fifo_data_o,
  input  logic                         fifo_fulln_i,
  output logic [NB_SRC-1:0]            lost_evt_o,
  output logic [CNT_WIDTH-1:0]         lost_cnt_o,
  input  logic                         clear_lost_i
);

  localparam int PTR_W = $clog2(NB_SRC);
  localparam int SUM_W = CNT_WIDTH + PTR_W + 1;

  logic [NB_SRC-1:0]    pending_q, pending_d;
  logic [ID_WIDTH-1:0]  pend_id_q [NB_SRC];
  logic [ID_WIDTH-1:0]  pend_id_d [NB_SRC];
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 valid_q, valid_d;
  logic [ID_WIDTH-1:0]  data_q, data_d;
  logic [NB_SRC-1:0]    lost_q, lost_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 adv;
  logic                 arb_go;
  logic [NB_SRC-1:0]    gnt_onehot;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [NB_SRC-1:0]    lose_now;
  logic [SUM_W-1:0]     cnt_sum;

  assign adv    = ~valid_q | fifo_fulln_i;
  assign arb_go = adv & arb_en_i;

  soc_evt_rr_arbiter #(
    .NB_SRC (NB_SRC),
    .PTR_W  (PTR_W)
  ) u_rr (
    .req        (pending_q),
    .ptr        (rr_ptr_q),
    .en         (arb_go),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  // A slot granted this cycle is free again, so a same-cycle pulse refills it.
  always_comb begin
    pending_d = pending_q & ~gnt_onehot;
    lose_now  = '0;
    for (int i = 0; i < NB_SRC; i++) begin
      pend_id_d[i] = pend_id_q[i];
      if (src_evt_i[i]) begin
        if (!pending_d[i]) begin
          pending_d[i] = 1'b1;
          pend_id_d[i] = src_id_i[i*ID_WIDTH +: ID_WIDTH];
        end else begin
          lose_now[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      valid_d  = 1'b1;
      data_d   = pend_id_q[gnt_idx];
      rr_ptr_d = (gnt_idx == PTR_W'(NB_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  // Clear takes effect before this cycle's losses are accumulated.
  always_comb begin
    lost_d  = (clear_lost_i ? '0 : lost_q) | lose_now;
    cnt_sum = clear_lost_i ? '0 : SUM_W'(cnt_q);
    for (int i = 0; i < NB_SRC; i++) begin
      cnt_sum = cnt_sum + SUM_W'(lose_now[i]);
    end
    if (|cnt_sum[SUM_W-1:CNT_WIDTH]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      lost_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NB_SRC; i++) begin
        pend_id_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      lost_q    <= lost_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < NB_SRC; i++) begin
        pend_id_q[i] <= pend_id_d[i];
      end
    end
  end

  assign fifo_data_valid_o = valid_q;
  assign fifo_data_o       = data_q;
  assign lost_evt_o        = lost_q;
  assign lost_cnt_o        = cnt_q;

endmodule

// File: tb/tb_soc_evt_fifo_arbiter.sv
// Directed self-checking bench for the event FIFO arbiter (4 sources, 8-bit IDs).
module tb_soc_evt_fifo_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  src_evt;
  logic [31:0] src_id;
  logic        arb_en;
  logic        valid;
  logic [7:0]  data;
  logic        fulln;
  logic [3:0]  lost_evt;
  logic [7:0]  lost_cnt;
  logic        clear_lost;

  int checks = 0;
  int errors = 0;

  soc_evt_fifo_arbiter #(
    .NB_SRC    (4),
    .ID_WIDTH  (8),
    .CNT_WIDTH (8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .src_evt_i         (src_evt),
    .src_id_i          (src_id),
    .arb_en_i          (arb_en),
    .fifo_data_valid_o (valid),
    .fifo_data_o       (data),
    .fifo_fulln_i      (fulln),
    .lost_evt_o        (lost_evt),
    .lost_cnt_o        (lost_cnt),
    .clear_lost_i      (clear_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int idx, input logic [7:0] val);
    src_id[idx*8 +: 8] = val;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; src_evt = '0; src_id = '0; arb_en = 1'b1; fulln = 1'b1; clear_lost = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_valid", 32'(valid), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_lost_evt", 32'(lost_evt), 0);
    chk("reset_lost_cnt", 32'(lost_cnt), 0);

    // Single event on source 2: visible only at t+2
    set_id(2, 8'h15); src_evt = 4'b0100;
    tick(); src_evt = '0;
    chk("single_t1_valid", 32'(valid), 0);
    tick();
    chk("single_t2_valid", 32'(valid), 1);
    chk("single_t2_data", 32'(data), 32'h15);
    tick();
    chk("single_t3_valid", 32'(valid), 0);

    // Fairness from rr_ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    set_id(0, 8'hA0); set_id(1, 8'hA1); set_id(2, 8'hA2); set_id(3, 8'hA3);
    src_evt = 4'b1111;
    tick(); src_evt = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr_valid_%0d", k), 32'(valid), 1);
      chk($sformatf("rr_data_%0d", k), 32'(data), 32'hA0 + 32'(k));
    end
    tick();
    chk("rr_drain_valid", 32'(valid), 0);
    // Pointer back at 0: source 0 wins over source 1
    set_id(0, 8'hB0); set_id(1, 8'hB1); src_evt = 4'b0011;
    tick(); src_evt = '0;
    tick();
    chk("rr_wrap_first", 32'(data), 32'hB0);
    tick();
    chk("rr_wrap_second", 32'(data), 32'hB1);
    tick();
    chk("rr_wrap_idle", 32'(valid), 0);

    // Backpressure: 0x33 held for 5 stalled cycles, 0x44 waits behind it
    set_id(2, 8'h33); src_evt = 4'b0100;
    tick();
    fulln = 1'b0; set_id(3, 8'h44); src_evt = 4'b1000;
    tick(); src_evt = '0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_valid_%0d", k), 32'(valid), 1);
      chk($sformatf("stall_data_%0d", k), 32'(data), 32'h33);
      tick();
    end
    fulln = 1'b1;
    tick();
    chk("stall_next_valid", 32'(valid), 1);
    chk("stall_next_data", 32'(data), 32'h44);
    tick();
    chk("stall_drain_valid", 32'(valid), 0);

    // Loss: second pulse on source 1 while its slot is still occupied
    fulln = 1'b0; set_id(0, 8'h50); src_evt = 4'b0001;
    tick(); src_evt = '0;
    tick();
    chk("loss_stage_data", 32'(data), 32'h50);
    set_id(1, 8'h10); src_evt = 4'b0010;
    tick();
    set_id(1, 8'h11);
    tick(); src_evt = '0;
    chk("loss_flag", 32'(lost_evt), 32'b0010);
    chk("loss_cnt", 32'(lost_cnt), 1);
    fulln = 1'b1;
    tick();
    chk("loss_deliver_data", 32'(data), 32'h10);
    tick();
    chk("loss_no_second", 32'(valid), 0);

    // Recapture: source 0 pulses in the cycle its slot is granted
    set_id(0, 8'hC0); src_evt = 4'b0001;
    tick();
    set_id(0, 8'hC1);
    tick(); src_evt = '0;
    chk("recap_first_data", 32'(data), 32'hC0);
    chk("recap_no_loss_cnt", 32'(lost_cnt), 1);
    tick();
    chk("recap_second_valid", 32'(valid), 1);
    chk("recap_second_data", 32'(data), 32'hC1);
    tick();
    chk("recap_idle", 32'(valid), 0);

    clear_lost = 1'b1; tick(); clear_lost = 1'b0;
    chk("clear_flags", 32'(lost_evt), 0);
    chk("clear_cnt", 32'(lost_cnt), 0);

    // Saturation: stall, fill every slot, then 75 cycles x 4 losses = 300
    fulln = 1'b0;
    set_id(0, 8'hD0); set_id(1, 8'hD1); set_id(2, 8'hD2); set_id(3, 8'hD3);
    src_evt = 4'b1111;
    tick(); src_evt = '0;
    tick();
    chk("sat_stage_data", 32'(data), 32'hD1);
    src_evt = 4'b0010;
    tick();
    chk("sat_refill_no_loss", 32'(lost_cnt), 0);
    src_evt = 4'b1111;
    for (int k = 0; k < 63; k++) tick();
    chk("sat_cnt_252", 32'(lost_cnt), 252);
    for (int k = 0; k < 12; k++) tick();
    src_evt = '0;
    chk("sat_cnt_255", 32'(lost_cnt), 255);
    chk("sat_flags", 32'(lost_evt), 32'hF);
    clear_lost = 1'b1; src_evt = 4'b0001;
    tick(); clear_lost = 1'b0; src_evt = '0;
    chk("clear_loss_cnt", 32'(lost_cnt), 1);
    chk("clear_loss_flags", 32'(lost_evt), 32'b0001);

    // Reset in the middle of a burst
    fulln = 1'b1;
    tick();
    chk("burst_data", 32'(data), 32'hD2);
    rst = 1'b1; src_evt = 4'b1111;
    tick(); rst = 1'b0; src_evt = '0;
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_data", 32'(data), 0);
    chk("midrst_flags", 32'(lost_evt), 0);
    chk("midrst_cnt", 32'(lost_cnt), 0);
    tick();
    chk("midrst_after1", 32'(valid), 0);
    tick();
    chk("midrst_after2", 32'(valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
